keypad_scan_writer: RTL

- Scans a 4x4 active-low matrix keypad and debounces presses. Encodes each accepted key as a 4-bit hex code.
- Drives the write side of the 8-digit display latch bank (data4/en/cs), so each accepted key is written into the next digit position.
- Sits between the board keypad pins and the display scanner's latch-write inputs.

---
 rtl/keypad_scan_writer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_writer.sv
// keypad_scan_writer
//   Scans a 4x4 active-low matrix keypad one row per scan tick, debounces
//   whole-frame results, and writes every accepted key (4-bit hex code) into
//   the next digit of an 8-digit display latch bank.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous reset, active low
//   col_n[3:0] in   keypad columns (pulled up, low = closed in driven row)
//   row_n[3:0] out  keypad row drive, exactly one bit low
//   key_code   out  last accepted key code (row*4 + col)
//   key_valid  out  one-clk pulse per accepted key
//   key_held   out  high from accept until release is debounced
//   data4      out  display write data (mirrors key_code)
//   en         out  display write enable, coincident with key_valid
//   cs[2:0]    out  display digit select / write pointer
//   fsm_state  out  debounce FSM state (IDLE=0, DEB=1, HELD=2, REL=3)
//
// Handshake: en/key_valid are single-cycle strobes with no back-pressure.
// data4 and cs are stable for the whole cycle en is high; cs advances only on
// the cycle after en, so the latch bank never sees en with a moving pointer.
module keypad_scan_writer #(
  parameter int CLK_DIV = 5000,
  parameter int DEB_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] data4,
  output logic       en,
  output logic [2:0] cs,
  output logic [1:0] fsm_state
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    row_idx;
  logic [11:0]   acc;        // closed bits of rows 0..2 for the frame in progress
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    cand;
  logic [3:0]    cand_nx;
  logic          do_emit;
  logic          frame_done;
  logic [15:0]   closed;
  logic [1:0]    hits;       // saturates at 2: 0 = NONE, 1 = ONE, 2 = MULTI
  logic [3:0]    hit_idx;
  logic          res_none;
  logic          res_one;

  assign tick       = (tick_cnt == TICK_LAST);
  assign frame_done = tick && (row_idx == 2'd3);
  assign fsm_state  = state;
  assign data4      = key_code;
  assign en         = key_valid;
  assign cnt_inc    = cnt + CW'(1);

  // Row 3 is classified straight from the pins on the frame-completing tick.
  assign closed = {~col_n, acc};

  always_comb begin
    hits    = 2'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (closed[i]) begin
        if (hits != 2'd2) hits = hits + 2'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign res_none = (hits == 2'd0);
  assign res_one  = (hits == 2'd1);

  // Debounce transition for one completed frame.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    do_emit  = 1'b0;
    case (state)
      IDLE: begin
        if (res_one) begin
          cand_nx = hit_idx;
          cnt_nx  = CW'(1);
          if (DEB_CNT == 1) begin
            state_nx = HELD;
            do_emit  = 1'b1;
          end else begin
            state_nx = DEB;
          end
        end
      end
      DEB: begin
        if (res_one && hit_idx == cand) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == DEB_LAST) begin
            state_nx = HELD;
            do_emit  = 1'b1;
          end
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      HELD: begin
        // No auto-repeat: any key activity keeps us here.
        if (res_none) begin
          cnt_nx   = CW'(1);
          state_nx = (DEB_CNT == 1) ? IDLE : REL;
        end
      end
      REL: begin
        if (res_none) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == DEB_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end else begin
          state_nx = HELD;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      row_idx   <= 2'd0;
      row_n     <= 4'b1110;
      acc       <= '0;
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      cs        <= 3'd0;
    end else begin
      key_valid <= 1'b0;
      // Pointer moves on the cycle after the write strobe.
      if (key_valid) cs <= cs + 3'd1;

      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

      if (tick) begin
        row_idx <= row_idx + 2'd1;
        row_n   <= ~(4'b0001 << (row_idx + 2'd1));
        case (row_idx)
          2'd0: acc[3:0]  <= ~col_n;
          2'd1: acc[7:4]  <= ~col_n;
          2'd2: acc[11:8] <= ~col_n;
          default: begin
            acc      <= '0;
            state    <= state_nx;
            cnt      <= cnt_nx;
            cand     <= cand_nx;
            key_held <= (state_nx == HELD) || (state_nx == REL);
            if (do_emit) begin
              key_valid <= 1'b1;
              key_code  <= cand_nx;
            end
          end
        endcase
      end
    end
  end

endmodule
